// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin / forced-select stream multiplexer.
package rr_stream_mux_pkg;

    // Selection mode carried on the 1-bit `mode` port.
    typedef enum logic {
        MODE_RR     = 1'b0,
        MODE_FORCED = 1'b1
    } mux_mode_e;

    // Smallest channel count the multiplexer is meant to be built with.
    localparam int unsigned MIN_NUM_IN = 2;

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Round-robin arbiter: rotating priority starting after the last granted
// channel. Grants are one-hot and forced to zero when `en` is low.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              en,
    input  logic              update,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] last_grant;
    // One spare bit so last_grant + k cannot overflow before the wrap.
    logic [SEL_W:0]   cand;
    logic             found;

    // Scan channels last_grant+1 .. last_grant+NUM_IN (mod NUM_IN); first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            cand = {1'b0, last_grant} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_IN)) begin
                cand = cand - (SEL_W+1)'(NUM_IN);
            end
            if (en && !found && req[cand[SEL_W-1:0]]) begin
                grant[cand[SEL_W-1:0]] = 1'b1;
                grant_idx              = cand[SEL_W-1:0];
                found                  = 1'b1;
            end
        end
    end

    // Pointer register: reset makes channel 0 the highest priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= SEL_W'(NUM_IN - 1);
        end else if (update) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-input valid/ready stream multiplexer with a single registered output
// stage. Selection is round-robin or a forced channel index.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic              load_en;
    logic              xfer;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  sel_data;

    // Output register can take a new beat when empty or being drained.
    assign load_en = !out_valid || out_ready;

    // Request masking: forced mode exposes only channel force_sel, so each
    // in_ready bit depends on its own in_valid alone; out-of-range never matches.
    always_comb begin
        req = '0;
        if (mux_mode_e'(mode) == MODE_FORCED) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                req[i] = in_valid[i] && (force_sel == SEL_W'(i));
            end
        end else begin
            req = in_valid;
        end
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (load_en),
        .update    (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are only issued to valid requesters, so any grant is a transfer.
    assign in_ready = grant;
    assign xfer     = |grant;

    // AND-OR data select driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: load on transfer, clear valid when drained with nothing new.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed + randomised bench for rr_stream_mux with a cycle-level reference
// model and an in-order scoreboard of accepted beats.
module tb_rr_stream_mux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [SW-1:0]    force_sel;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_src;
    logic             out_valid;
    logic             out_ready;

    // Three-channel instance for out-of-range forced index.
    logic [3*W-1:0]   in_data3;
    logic [2:0]       in_valid3;
    logic [2:0]       in_ready3;
    logic             mode3;
    logic [1:0]       force_sel3;
    logic [W-1:0]     out_data3;
    logic [1:0]       out_src3;
    logic             out_valid3;
    logic             out_ready3;

    rr_stream_mux #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .force_sel(force_sel),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_stream_mux #(.WIDTH(W), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .force_sel(force_sel3),
        .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit         m_known = 0;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_src;
    int         m_ptr;
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check current state, predict next, advance to the next negedge.
    task automatic cycle();
        int         win;
        bit         le;
        logic [N-1:0] exp_rdy;
        #1;
        if (m_known) begin
            chk("out_valid", out_valid, m_valid);
            chk("out_data", out_data, m_data);
            chk("out_src", out_src, m_src);
        end
        le  = !m_valid || out_ready;
        win = -1;
        if (le) begin
            if (mode == 1'b0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (win < 0 && in_valid[c]) win = c;
                end
            end else if (int'(force_sel) < N && in_valid[force_sel]) begin
                win = int'(force_sel);
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        if (m_known && rst_n) begin
            chk("in_ready", in_ready, exp_rdy);
            chk("in_ready_onehot0", $onehot0(in_ready), 1);
            if (out_valid && out_ready) begin
                if (sb_q.size() > 0) chk("sb_order", out_data, sb_q.pop_front());
                else chk("sb_extra_beat", sb_q.size(), 1);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1;
            m_valid = 0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = N - 1;
            sb_q.delete();
        end else if (m_known && le) begin
            if (win >= 0) begin
                m_valid = 1;
                m_data  = in_data[win*W +: W];
                m_src   = win;
                m_ptr   = win;
                sb_q.push_back(m_data);
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    logic [7:0] t1_exp [5];

    initial begin
        t1_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        force_sel3 = '0;
        out_ready3 = 1'b1;

        // Fairness sequence after reset
        rst_n     = 1'b0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'b1111;
        mode      = 1'b0;
        force_sel = '0;
        out_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
        chk("t1_idle_after_reset", out_valid, 0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t1_data", out_data, t1_exp[k]);
            chk("t1_src", out_src, k % N);
        end

        // Backpressure hold after first beat
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("t2_first", out_data, 8'hA0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t2_hold_data", out_data, 8'hA0);
            chk("t2_hold_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        cycle();
        chk("t2_next", out_data, 8'hA1);

        // Forced select
        mode      = 1'b1;
        force_sel = 2'd2;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_data", out_data, 8'h33);
            chk("t3_ready", in_ready, 4'b0100);
        end

        // Out-of-range forced index on the three-channel instance
        in_valid   = '0;
        mode       = 1'b0;
        in_data3   = {8'h33, 8'h22, 8'h11};
        in_valid3  = 3'b111;
        mode3      = 1'b1;
        force_sel3 = 2'd2;
        #1;
        chk("t3n3_ready_in", in_ready3, 3'b100);
        cycle();
        chk("t3n3_valid", out_valid3, 1);
        chk("t3n3_data", out_data3, 8'h33);
        force_sel3 = 2'd3;
        #1;
        chk("t3n3_oor_ready", in_ready3, 3'b000);
        cycle();
        chk("t3n3_drained", out_valid3, 0);
        chk("t3n3_data_kept", out_data3, 8'h33);
        in_valid3 = '0;

        // Lone requester, then pointer-based priority
        in_data  = {8'h5C, 8'h00, 8'h00, 8'h10};
        in_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t4_src", out_src, 3);
            chk("t4_data", out_data, 8'h5C);
        end
        in_valid = 4'b1001;
        cycle();
        chk("t4_wrap_src", out_src, 0);

        // Reset during backpressure
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        cycle();
        chk("t5_held", out_valid, 1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        out_ready = 1'b1;
        #1;
        chk("t5_first_grant", in_ready, 4'b0001);
        cycle();
        chk("t5_src", out_src, 0);

        // Randomised traffic
        for (int k = 0; k < 10000; k++) begin
            in_valid  = N'($urandom);
            in_data   = {$urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = ($urandom_range(0, 7) == 0);
            force_sel = SW'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
